// File: rtl/ahb_lite_eic_bridge.sv
// rtl/ahb_lite_eic_bridge.sv - AHB-Lite slave bridge onto the EIC register port
module ahb_lite_eic_bridge #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]           read_data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic                  write_enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RWAIT,
    S_RDONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic                  legal;
  logic [ADDR_WIDTH-1:0] index;
  logic                  unused_bits;

  // Bursts are treated as independent singles; upper address bits are aliased.
  assign unused_bits = ^{HBURST, HADDR[31:ADDR_WIDTH+2]};

  assign index  = HADDR[ADDR_WIDTH+1:2];
  assign accept = HSEL & HTRANS[1] & HREADY;
  assign legal  = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RWAIT: state_next = S_RDONE;
      S_ERR1:  state_next = S_ERR2;
      default: begin
        if (!accept) begin
          state_next = S_IDLE;
        end else if (!legal) begin
          state_next = S_ERR1;
        end else if (HWRITE) begin
          state_next = S_WRITE;
        end else begin
          state_next = S_RWAIT;
        end
      end
    endcase
  end

  // HREADY/HRESP depend on state only, so no address-phase input reaches them.
  always_comb begin
    HREADY       = 1'b1;
    HRESP        = 1'b0;
    write_enable = 1'b0;
    case (state)
      S_WRITE: write_enable = 1'b1;
      S_RWAIT: HREADY       = 1'b0;
      S_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      S_ERR2:  HRESP        = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      read_addr  <= '0;
      write_addr <= '0;
      HRDATA     <= '0;
    end else begin
      if (accept && legal && HWRITE) begin
        write_addr <= index;
      end
      if (accept && legal && !HWRITE) begin
        read_addr <= index;
      end
      if (state == S_RWAIT) begin
        HRDATA <= read_data;
      end
    end
  end

  assign write_data = HWDATA;

endmodule

// File: tb/tb_ahb_lite_eic_bridge.sv
// tb/tb_ahb_lite_eic_bridge.sv - scoreboard bench for ahb_lite_eic_bridge
module tb_ahb_lite_eic_bridge;

  localparam int AW     = 5;
  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_ERR  = 3;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADY;
  logic          HRESP;
  logic [AW-1:0] read_addr;
  logic [31:0]   read_data;
  logic [AW-1:0] write_addr;
  logic [31:0]   write_data;
  logic          write_enable;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } wr_t;

  xfer_t       seq[$];
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_regs [32];
  logic [31:0] eic_mem [32];
  logic [31:0] last_rd;
  logic        mem_clr;
  wr_t         mon_w;
  int          total = 0;
  int          bad   = 0;

  ahb_lite_eic_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HSEL         (HSEL),
    .HADDR        (HADDR),
    .HTRANS       (HTRANS),
    .HWRITE       (HWRITE),
    .HSIZE        (HSIZE),
    .HBURST       (HBURST),
    .HWDATA       (HWDATA),
    .HRDATA       (HRDATA),
    .HREADY       (HREADY),
    .HRESP        (HRESP),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable)
  );

  always #5 HCLK = ~HCLK;

  // Stand-in EIC register file.
  assign read_data = eic_mem[read_addr];
  always @(posedge HCLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) eic_mem[i] <= '0;
    end else if (write_enable) begin
      eic_mem[write_addr] <= write_data;
    end
  end

  always @(negedge HCLK) begin
    if (write_enable === 1'b1) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL stray_write: write_enable=1 idx=%0d data=%h, want no write", write_addr, write_data);
      end else begin
        mon_w = wr_q.pop_front();
        if (write_addr !== mon_w.idx || write_data !== mon_w.data) begin
          bad++;
          $display("FAIL write_port: got idx=%0d data=%h want idx=%0d data=%h",
                   write_addr, write_data, mon_w.idx, mon_w.data);
        end
      end
    end
  end

  function automatic xfer_t mk(logic sel, logic [1:0] trans, logic wr, logic [2:0] size,
                               logic [31:0] addr, logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
    return x;
  endfunction

  function automatic xfer_t wr_x(logic [31:0] addr, logic [31:0] data);
    return mk(1'b1, 2'b10, 1'b1, 3'b010, addr, data);
  endfunction

  function automatic xfer_t rd_x(logic [31:0] addr);
    return mk(1'b1, 2'b10, 1'b0, 3'b010, addr, 32'h0);
  endfunction

  function automatic xfer_t idle_x();
    return mk(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
  endfunction

  function automatic int kind_of(xfer_t x);
    if (!(x.sel && x.trans[1])) return K_NONE;
    if (x.size != 3'b010 || x.addr[1:0] != 2'b00) return K_ERR;
    return x.wr ? K_WR : K_RD;
  endfunction

  task automatic drive_addr(xfer_t x);
    HSEL   = x.sel;
    HTRANS = x.trans;
    HWRITE = x.wr;
    HSIZE  = x.size;
    HADDR  = x.addr;
    HBURST = 3'($urandom_range(0, 7));
  endtask

  task automatic accept_model(xfer_t x);
    int            k;
    logic [AW-1:0] i;
    wr_t           w;
    k = kind_of(x);
    i = x.addr[AW+1:2];
    if (k == K_WR) begin
      exp_regs[i] = x.wdata;
      w.idx = i;
      w.data = x.wdata;
      wr_q.push_back(w);
    end else if (k == K_RD) begin
      rd_q.push_back(exp_regs[i]);
    end
  endtask

  // Pipelined AHB master: runs seq, checks each data phase as it completes.
  task automatic run_seq(string name);
    xfer_t       ap;
    xfer_t       dp;
    bit          ap_v;
    bit          dp_v;
    int          dk;
    int          waits;
    int          guard;
    logic        hr;
    logic [31:0] expd;
    ap_v = 0; dp_v = 0; dk = K_NONE; waits = 0; guard = 0; hr = 1'b1;
    ap = idle_x(); dp = ap;
    while ((seq.size() != 0 || ap_v || dp_v) && guard < 500) begin
      guard++;
      if (hr === 1'b1) begin
        dp_v = ap_v; dp = ap; dk = kind_of(ap); waits = 0;
        if (ap_v) accept_model(ap);
        ap_v = (seq.size() != 0);
        if (ap_v) ap = seq.pop_front(); else ap = idle_x();
        drive_addr(ap);
      end
      HWDATA = (dp_v && dk == K_WR) ? dp.wdata : $urandom();
      @(negedge HCLK);
      total++;
      if (HRESP !== (dp_v && dk == K_ERR)) begin
        bad++;
        $display("FAIL %s hresp: got %b want %b (kind %0d)", name, HRESP, (dp_v && dk == K_ERR), dk);
      end
      if (HREADY === 1'b1) begin
        if (dp_v) begin
          total++;
          if (waits != ((dk == K_RD || dk == K_ERR) ? 1 : 0)) begin
            bad++;
            $display("FAIL %s wait_states: got %0d want %0d (kind %0d)", name, waits,
                     ((dk == K_RD || dk == K_ERR) ? 1 : 0), dk);
          end
          if (dk == K_RD) begin
            expd = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hxxxx_xxxx;
            last_rd = expd;
          end
          total++;
          if (HRDATA !== last_rd) begin
            bad++;
            $display("FAIL %s hrdata: got %h want %h (kind %0d addr %h)", name, HRDATA, last_rd, dk, dp.addr);
          end
        end
        dp_v = 0;
      end else begin
        waits++;
        if (!dp_v || waits > 4) begin
          total++;
          bad++;
          $display("FAIL %s hready_stuck: got HREADY=%b want 1 (waits %0d)", name, HREADY, waits);
          guard = 500;
        end
      end
      hr = HREADY;
      @(posedge HCLK);
      #1;
    end
    drive_addr(idle_x());
    total++;
    if (guard >= 500 || wr_q.size() != 0 || rd_q.size() != 0) begin
      bad++;
      $display("FAIL %s drain: got %0d writes %0d reads outstanding (guard %0d) want 0", name,
               wr_q.size(), rd_q.size(), guard);
      wr_q.delete();
      rd_q.delete();
    end
  endtask

  task automatic check_reset_outputs(string name);
    total++;
    if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0 || write_enable !== 1'b0) begin
      bad++;
      $display("FAIL %s outputs: got HREADY=%b HRESP=%b HRDATA=%h we=%b want 1 0 0 0",
               name, HREADY, HRESP, HRDATA, write_enable);
    end
    total++;
    if (read_addr !== '0 || write_addr !== '0) begin
      bad++;
      $display("FAIL %s indices: got ra=%0d wa=%0d want 0 0", name, read_addr, write_addr);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    mem_clr = 1'b1;
    drive_addr(idle_x());
    HWDATA = '0;
    repeat (2) @(posedge HCLK);
    #1;
    check_reset_outputs("reset_held");
    HRESET = 1'b0;
    mem_clr = 1'b0;
    @(negedge HCLK);
    check_reset_outputs("reset_released");
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_write_readback();
    seq.push_back(wr_x(32'h10, 32'h03));
    seq.push_back(wr_x(32'h14, 32'h01));
    seq.push_back(wr_x(32'h14, 32'h00));
    seq.push_back(rd_x(32'h10));
    seq.push_back(rd_x(32'h14));
    run_seq("write_readback");
  endtask

  task automatic test_read_after_write();
    seq.push_back(wr_x(32'h08, 32'hA5));
    seq.push_back(rd_x(32'h08));
    run_seq("read_after_write");
  endtask

  task automatic test_errors();
    seq.push_back(wr_x(32'h10, 32'h55));
    seq.push_back(mk(1'b1, 2'b10, 1'b1, 3'b000, 32'h10, 32'hAA));
    seq.push_back(mk(1'b1, 2'b10, 1'b0, 3'b010, 32'h11, 32'h0));
    seq.push_back(rd_x(32'h10));
    seq.push_back(mk(1'b1, 2'b11, 1'b1, 3'b001, 32'h12, 32'hBB));
    seq.push_back(wr_x(32'h1C, 32'h77));
    seq.push_back(rd_x(32'h1C));
    run_seq("errors");
  endtask

  task automatic test_ignored_cycles();
    seq.push_back(wr_x(32'h04, 32'h1234_5678));
    seq.push_back(mk(1'b1, 2'b00, 1'b1, 3'b010, 32'h04, 32'h0));
    seq.push_back(mk(1'b1, 2'b01, 1'b1, 3'b010, 32'h04, 32'h0));
    seq.push_back(mk(1'b0, 2'b10, 1'b1, 3'b010, 32'h04, 32'h0));
    seq.push_back(rd_x(32'h04));
    seq.push_back(mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h10, 32'h0));
    seq.push_back(mk(1'b0, 2'b10, 1'b0, 3'b010, 32'h10, 32'h0));
    seq.push_back(mk(1'b0, 2'b11, 1'b1, 3'b010, 32'h18, 32'h0));
    seq.push_back(rd_x(32'h10));
    seq.push_back(rd_x(32'h18));
    seq.push_back(rd_x(32'h84));
    run_seq("ignored_cycles");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    seq.push_back(wr_x(32'($urandom_range(0, 31)) << 2, $urandom()));
        2, 3:    seq.push_back(rd_x(32'($urandom_range(0, 31)) << 2));
        default: seq.push_back(mk(1'b1, 2'b10, 1'($urandom_range(0, 1)), 3'b010,
                                  (32'($urandom_range(0, 31)) << 2) | 32'h2, $urandom()));
      endcase
    end
    run_seq("back_to_back");
  endtask

  task automatic test_reset_during_read();
    seq.push_back(rd_x(32'h10));
    run_seq("pre_reset_read");
    drive_addr(rd_x(32'h10));
    @(posedge HCLK);
    #1;
    drive_addr(idle_x());
    total++;
    if (HREADY !== 1'b0) begin
      bad++;
      $display("FAIL rwait_entry: got HREADY=%b want 0", HREADY);
    end
    #2;
    HRESET = 1'b1;
    #1;
    check_reset_outputs("reset_in_rwait");
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    last_rd = '0;
    drive_addr(wr_x(32'h0C, 32'h0));
    @(posedge HCLK);
    #1;
    drive_addr(idle_x());
    HWDATA = 32'hDEAD_BEEF;
    total++;
    if (write_enable !== 1'b1) begin
      bad++;
      $display("FAIL write_state_entry: got write_enable=%b want 1", write_enable);
    end
    #2;
    HRESET = 1'b1;
    #1;
    total++;
    if (write_enable !== 1'b0 || HREADY !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_write: got we=%b HREADY=%b want 0 1", write_enable, HREADY);
    end
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    seq.push_back(rd_x(32'h10));
    seq.push_back(rd_x(32'h0C));
    run_seq("after_reset_read");
  endtask

  initial begin
    HRESET  = 1'b1;
    mem_clr = 1'b1;
    last_rd = '0;
    HWDATA  = '0;
    drive_addr(idle_x());
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    test_reset();
    test_write_readback();
    test_read_after_write();
    test_errors();
    test_ignored_cycles();
    test_reset_during_read();
    test_back_to_back();
    repeat (2) @(posedge HCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
